serial_txd_arbiter: RTL and testbench
=====================================

# serial_txd_arbiter

Round-robin arbiter that shares the single WISHBONE serial transmitter (115200-baud UART TX slave on clk_30) between four byte-stream requesters, such as debug/trace sources.
- Accepts bytes over per-requester valid/ready handshakes and runs one WISHBONE write cycle per byte.
- Holds the grant across multi-byte messages until the requester marks the last byte.
- Sits between the trace sources and the transmitter slave's CYC/STB/WE/DAT/ACK port.

## Interface
Parameters:
- TIMEOUT_CYCLES, 13'd4096, BUS-state cycles before a write is abandoned (used only with the timeout feature; a byte nominally takes 2600 cycles).

Ports:
- clk_30  in  1  system clock, all logic on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- req_valid  in  4  requester i has a byte on req_data[8i+7:8i].
- req_data  in  32  four packed bytes, requester i at bits [8i+7:8i].
- req_last  in  4  byte from requester i ends its message (releases lock).
- req_ready  out  4  combinational, one-hot; byte of requester i accepted this cycle.
- CYC_O  out  1  WISHBONE cycle, registered.
- STB_O  out  1  WISHBONE strobe, registered, equal to CYC_O.
- WE_O  out  1  write enable, registered, equal to CYC_O.
- DAT_O  out  8  byte being sent, registered.
- ACK_I  in  1  transmitter done; stays high until one cycle after STB_O falls.
- owner  out  2  index of current/last granted requester.
- locked  out  1  message in progress; only owner may be granted.
- tx_timeout  out  1  one-cycle pulse on an abandoned write.

## Operation
- Reset values: CYC_O/STB_O/WE_O=0, DAT_O=8'h00, owner=0, locked=0, tx_timeout=0, rr pointer=0, state IDLE. req_ready is 0 while reset_n=0.
- States:
  - IDLE → BUS when a byte is accepted.
  - BUS → GAP on ACK_I=1, or on timeout when enabled.
  - GAP → IDLE when ACK_I=0.
- IDLE winner selection:
  - If locked, the winner is owner, and only if req_valid[owner]=1.
  - Otherwise, the winner is the first set req_valid bit scanning from rr pointer upward, mod 4.
  - req_ready[winner]=1 only in IDLE with a winner. All other bits are 0.
- On accept:
  - DAT_O ← winner's byte; CYC/STB/WE ← 1; owner ← winner.
  - locked ← ~req_last[winner].
  - If req_last[winner]=1, rr pointer ← winner+1 (2-bit wrap, 3→0).
- BUS: outputs are held stable until ACK_I is sampled high. The following edge clears CYC/STB/WE. DAT_O keeps its value.
- GAP: no new cycle starts while ACK_I=1. This prevents re-triggering the slave, which restarts on a held STB.
- Lock: while locked, other requesters are starved even if owner's req_valid is low. This is intentional and keeps messages contiguous.
- Reset mid-operation: outputs clear immediately (async), any pending byte is lost, and the lock is released.

## Timing
- Accept edge → STB_O high: next cycle (latency 1).
- ACK_I sampled high at edge E → STB_O low after E. With the slave's registered ACK, ACK_I falls after E+1, and IDLE is entered at E+2.
- Minimum spacing between STB_O rising edges: the slave's byte time + 3 cycles. There is at most one byte in flight and no buffering.
- Simultaneous valids in IDLE: only one req_ready bit is set. The remaining requesters hold data and valid until accepted.
- Valid low on the owner during a lock: the arbiter sits in IDLE with no grant.

## Configuration
- SERIAL_TXD_ARB_TIMEOUT_EN defined:
  - A 13-bit counter clears on entering BUS and increments each BUS cycle.
  - When it reaches TIMEOUT_CYCLES-1 without ACK_I, the next edge drops CYC/STB/WE, pulses tx_timeout for 1 cycle, clears locked, sets rr pointer ← owner+1, and enters GAP.
- Undefined: no counter; BUS waits indefinitely for ACK_I; tx_timeout is tied 0.

## Test plan
- Single byte: req_valid=4'b0100, req_data[23:16]=8'hA5, req_last[2]=1.
  - Expect req_ready=4'b0100 for 1 cycle, STB_O next cycle, DAT_O=8'hA5.
  - Expect 10 UART bits 0,1,0,1,0,0,1,0,1,1 at 260 cycles each, then STB_O low and a return to IDLE 2 cycles after ACK_I.
- Fairness: all four valid with last=1 on every byte.
  - Expect grant order 0,1,2,3,0 and no requester granted twice before the others.
- Lock: requester 1 sends 3 bytes (last on the 3rd) while requester 3 is valid throughout.
  - Expect bytes 1,1,1 then 3, and locked=1 until the third byte is accepted.
- No re-trigger: a slave model holds ACK_I high for 5 cycles after STB_O falls.
  - Expect STB_O to stay low until ACK_I=0, then re-arm.
- Timeout (macro on, TIMEOUT_CYCLES=16): ACK_I tied 0.
  - Expect STB_O low after 16 BUS cycles, a tx_timeout pulse, locked=0, and the next requester granted.
- Reset mid-byte: reset_n low for 3 cycles during BUS.
  - Expect CYC/STB immediately 0, owner=0, and a fresh grant after release.

Source files
------------

// File: rtl/serial_txd_arbiter.sv
// Four-way round-robin arbiter with message lock, sharing one WISHBONE byte transmitter.
// Optional BUS-state write timeout: define SERIAL_TXD_ARB_TIMEOUT_EN.
module serial_txd_arbiter #(
  parameter logic [12:0] TIMEOUT_CYCLES = 13'd4096
) (
  input  logic        clk_30,
  input  logic        reset_n,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_last,
  output logic [3:0]  req_ready,
  output logic        CYC_O,
  output logic        STB_O,
  output logic        WE_O,
  output logic [7:0]  DAT_O,
  input  logic        ACK_I,
  output logic [1:0]  owner,
  output logic        locked,
  output logic        tx_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_GAP} state_t;

  state_t      r_state;
  logic        r_cyc;
  logic [7:0]  r_dat;
  logic [1:0]  r_owner;
  logic [1:0]  r_rr;
  logic        r_locked;

  logic        w_win_vld;
  logic [1:0]  w_win;
  logic [1:0]  w_idx;
  logic [7:0]  w_byte;

`ifdef SERIAL_TXD_ARB_TIMEOUT_EN
  logic [12:0] r_cnt;
  logic        r_tmo;
  assign tx_timeout = r_tmo;
`else
  logic        w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign tx_timeout       = 1'b0;
`endif

  // A held lock restricts the grant to the owner; otherwise scan upward from the rr pointer.
  always_comb begin
    w_win_vld = 1'b0;
    w_win     = r_owner;
    w_idx     = '0;
    if (r_locked) begin
      w_win_vld = req_valid[r_owner];
    end else begin
      for (int unsigned k = 0; k < 4; k++) begin
        w_idx = r_rr + 2'(k);
        if (!w_win_vld && req_valid[w_idx]) begin
          w_win_vld = 1'b1;
          w_win     = w_idx;
        end
      end
    end
  end

  assign w_byte    = req_data[{w_win, 3'b000} +: 8];
  assign req_ready = (reset_n && (r_state == S_IDLE) && w_win_vld) ? (4'b0001 << w_win) : '0;

  assign CYC_O  = r_cyc;
  assign STB_O  = r_cyc;
  assign WE_O   = r_cyc;
  assign DAT_O  = r_dat;
  assign owner  = r_owner;
  assign locked = r_locked;

  always_ff @(posedge clk_30 or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cyc    <= 1'b0;
      r_dat    <= '0;
      r_owner  <= '0;
      r_rr     <= '0;
      r_locked <= 1'b0;
`ifdef SERIAL_TXD_ARB_TIMEOUT_EN
      r_cnt    <= '0;
      r_tmo    <= 1'b0;
`endif
    end else begin
`ifdef SERIAL_TXD_ARB_TIMEOUT_EN
      r_tmo <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_win_vld) begin
            r_cyc    <= 1'b1;
            r_dat    <= w_byte;
            r_owner  <= w_win;
            r_locked <= ~req_last[w_win];
            if (req_last[w_win]) r_rr <= w_win + 2'd1;
            r_state  <= S_BUS;
`ifdef SERIAL_TXD_ARB_TIMEOUT_EN
            r_cnt    <= '0;
`endif
          end
        end
        S_BUS: begin
          if (ACK_I) begin
            r_cyc   <= 1'b0;
            r_state <= S_GAP;
          end
`ifdef SERIAL_TXD_ARB_TIMEOUT_EN
          else if (r_cnt == TIMEOUT_CYCLES - 13'd1) begin
            r_cyc    <= 1'b0;
            r_tmo    <= 1'b1;
            r_locked <= 1'b0;
            r_rr     <= r_owner + 2'd1;
            r_state  <= S_GAP;
          end else begin
            r_cnt <= r_cnt + 13'd1;
          end
`endif
        end
        // Slave restarts on a held STB, so wait for its ACK to drop first.
        S_GAP: begin
          if (!ACK_I) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_txd_arbiter.sv
// Bench for serial_txd_arbiter: per-requester message queues, UART-like ACK slave,
// transaction-level reference model compared every cycle, plus literal grant-order checks.
module tb_serial_txd_arbiter;

  localparam int TO = 16;

  logic        clk_30 = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic        CYC_O, STB_O, WE_O;
  logic [7:0]  DAT_O;
  logic        ACK_I = 1'b0;
  logic [1:0]  owner;
  logic        locked;
  logic        tx_timeout;

  serial_txd_arbiter #(.TIMEOUT_CYCLES(13'(TO))) dut (
    .clk_30(clk_30), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O),
    .DAT_O(DAT_O), .ACK_I(ACK_I), .owner(owner), .locked(locked), .tx_timeout(tx_timeout)
  );

  always #5 clk_30 = ~clk_30;

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0]  b;
    logic        last;
    int unsigned dly;
  } msg_t;

  msg_t mq [4][$];
  logic [3:0] acc = '0;
  int grants[$];
  logic txbits[$];
  int tmo_pulses = 0;

  // Slave: one bit per bit_time cycles, registered ACK held hold_extra cycles past STB fall.
  int bit_time = 260;
  int hold_extra = 0;
  bit ack_en = 1'b1;
  int s_cnt = 0;
  int h_cnt = 0;

  always @(posedge clk_30) begin
    if (!STB_O) begin
      if (ACK_I) begin
        if (h_cnt >= hold_extra) ACK_I <= 1'b0;
        else h_cnt <= h_cnt + 1;
      end else begin
        s_cnt <= 0;
        h_cnt <= 0;
      end
    end else if (ack_en && !ACK_I) begin
      if ((s_cnt % bit_time) == 0 && (s_cnt / bit_time) < 10) begin
        if (s_cnt == 0) txbits.push_back(1'b0);
        else if (s_cnt / bit_time == 9) txbits.push_back(1'b1);
        else txbits.push_back(DAT_O[s_cnt / bit_time - 1]);
      end
      if (s_cnt == 10 * bit_time - 1) ACK_I <= 1'b1;
      s_cnt <= s_cnt + 1;
    end
  end

  // Reference model: at most one byte in flight; busy from accept until ACK has been seen low after STB dropped.
  bit       m_busy = 1'b0;
  bit       m_stb = 1'b0;
  bit [7:0] m_dat = '0;
  int       m_owner = 0;
  int       m_rr = 0;
  bit       m_locked = 1'b0;
  bit       m_tmo = 1'b0;
  int       m_cnt = 0;

  function automatic int pick(logic [3:0] v, bit lk, int own, int rr);
    if (lk) return v[own] ? own : -1;
    for (int k = 0; k < 4; k++) if (v[(rr + k) % 4]) return (rr + k) % 4;
    return -1;
  endfunction

  always @(posedge clk_30 or negedge reset_n) begin : model
    int w;
    if (!reset_n) begin
      m_busy <= 1'b0; m_stb <= 1'b0; m_dat <= '0; m_owner <= 0;
      m_rr <= 0; m_locked <= 1'b0; m_tmo <= 1'b0; m_cnt <= 0;
    end else begin
      m_tmo <= 1'b0;
      w = pick(req_valid, m_locked, m_owner, m_rr);
      if (!m_busy) begin
        if (w >= 0) begin
          m_busy   <= 1'b1;
          m_stb    <= 1'b1;
          m_dat    <= req_data[8*w +: 8];
          m_owner  <= w;
          m_locked <= !req_last[w];
          if (req_last[w]) m_rr <= (w + 1) % 4;
          m_cnt    <= 0;
        end
      end else if (m_stb) begin
        if (ACK_I) m_stb <= 1'b0;
`ifdef SERIAL_TXD_ARB_TIMEOUT_EN
        else if (m_cnt == TO - 1) begin
          m_stb <= 1'b0; m_tmo <= 1'b1; m_locked <= 1'b0; m_rr <= (m_owner + 1) % 4;
        end else m_cnt <= m_cnt + 1;
`endif
      end else if (!ACK_I) begin
        m_busy <= 1'b0;
      end
    end
  end

  always @(negedge clk_30) begin : cmp
    int w;
    logic [3:0] er;
    w  = pick(req_valid, m_locked, m_owner, m_rr);
    er = (reset_n && !m_busy && w >= 0) ? 4'(1 << w) : 4'b0000;
    check("req_ready", req_ready, er);
    check("STB_O", STB_O, m_stb);
    check("CYC_O", CYC_O, m_stb);
    check("WE_O", WE_O, m_stb);
    check("DAT_O", DAT_O, m_dat);
    check("owner", owner, m_owner);
    check("locked", locked, m_locked);
    check("tx_timeout", tx_timeout, m_tmo);
    acc = req_ready;
    for (int i = 0; i < 4; i++) if (req_ready[i]) grants.push_back(i);
    if (tx_timeout) tmo_pulses++;
  end

  // Requester driver: presents the head of each queue, pops it once accepted.
  initial forever begin
    @(posedge clk_30);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (acc[i] && mq[i].size() > 0) void'(mq[i].pop_front());
      if (mq[i].size() > 0 && mq[i][0].dly > 0) begin
        mq[i][0].dly = mq[i][0].dly - 1;
        req_valid[i] = 1'b0;
      end else if (mq[i].size() > 0) begin
        req_valid[i]        = 1'b1;
        req_data[8*i +: 8]  = mq[i][0].b;
        req_last[i]         = mq[i][0].last;
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_30);
      #2;
    end
  endtask

  task automatic push(input int i, input logic [7:0] b, input logic last, input int unsigned dly);
    msg_t m;
    m.b = b; m.last = last; m.dly = dly;
    mq[i].push_back(m);
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int c = 0;
    while (c < budget && (mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size() != 0 || m_busy)) begin
      tick(1);
      c++;
    end
    check({nm, "_done"}, (c < budget) ? 1 : 0, 1);
  endtask

  task automatic check_grants(input string nm, input int exp[$]);
    check({nm, "_count"}, grants.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (i < grants.size()) check(nm, grants[i], exp[i]);
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
  endtask

  initial begin
    int eg[$];
    int c;
    tick(3);
    check("reset_STB", STB_O, 0);
    check("reset_ready", req_ready, 0);
    reset_n = 1'b1;
    tick(2);

    // Single byte from requester 2, UART-rate slave
    grants.delete(); txbits.delete();
    push(2, 8'hA5, 1'b1, 0);
    wait_idle("single", 4000);
    eg = {2};
    check_grants("single_grant", eg);
    eg = {0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    check("uart_bits_count", txbits.size(), 10);
    for (int i = 0; i < 10; i++) if (i < txbits.size()) check("uart_bit", txbits[i], eg[i]);

    // Fairness from a fresh rr pointer
    bit_time = 2;
    reset_pulse();
    grants.delete();
    for (int r = 0; r < 2; r++) for (int i = 0; i < 4; i++) push(i, 8'(16 * i + r), 1'b1, 0);
    wait_idle("fair", 2000);
    eg = {0, 1, 2, 3, 0, 1, 2, 3};
    check_grants("fair_order", eg);

    // Lock: requester 1 message of 3 bytes, owner idle mid-message, requester 3 waiting
    grants.delete();
    push(1, 8'h11, 1'b0, 0);
    push(1, 8'h12, 1'b0, 30);
    push(1, 8'h13, 1'b1, 0);
    push(3, 8'h33, 1'b1, 0);
    wait_idle("lock", 2000);
    eg = {1, 1, 1, 3};
    check_grants("lock_order", eg);

    // Slave holds ACK 5 cycles after STB falls
    grants.delete();
    hold_extra = 5;
    push(0, 8'h5A, 1'b1, 0);
    push(0, 8'hC3, 1'b1, 0);
    wait_idle("hold", 2000);
    eg = {0, 0};
    check_grants("hold_order", eg);
    hold_extra = 0;

`ifdef SERIAL_TXD_ARB_TIMEOUT_EN
    // Timeout with ACK never returned
    grants.delete();
    ack_en = 1'b0;
    tmo_pulses = 0;
    push(2, 8'h22, 1'b0, 0);
    push(3, 8'h44, 1'b1, 0);
    wait_idle("timeout", 500);
    eg = {2, 3};
    check_grants("timeout_order", eg);
    check("timeout_pulses", tmo_pulses, 2);
    ack_en = 1'b1;
`endif

    // Reset in the middle of a locked message
    grants.delete();
    bit_time = 20;
    push(1, 8'h71, 1'b0, 0);
    push(1, 8'h72, 1'b1, 0);
    c = 0;
    while (c < 50 && STB_O !== 1'b1) begin tick(1); c++; end
    check("reset_wait_stb", STB_O, 1);
    tick(5);
    check("locked_before_reset", locked, 1);
    check("owner_before_reset", owner, 1);
    reset_n = 1'b0;
    #1;
    check("async_STB", STB_O, 0);
    check("async_CYC", CYC_O, 0);
    check("async_owner", owner, 0);
    check("async_locked", locked, 0);
    tick(3);
    reset_n = 1'b1;
    wait_idle("post_reset", 2000);
    eg = {1, 1};
    check_grants("reset_order", eg);

    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
